// File: rtl/l1d_downstream_resp.sv
// L1D downstream port: forwards MSHR linefill/evict requests to the bus and assembles
// multi-beat linefill responses into full-line data RAM writes.
module l1d_downstream_resp #(
  parameter int unsigned MSHR_NUM = 8,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned ADDR_W   = 40,
  parameter int unsigned BEAT_W   = 128,
  parameter int unsigned BEATS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    downstream_req_vld,
  output logic                    downstream_req_rdy,
  input  logic [ID_W-1:0]         downstream_req_id,
  input  logic                    downstream_req_op,
  input  logic [ADDR_W-1:0]       downstream_req_addr,
  output logic                    bus_req_vld,
  input  logic                    bus_req_rdy,
  output logic [ID_W-1:0]         bus_req_id,
  output logic                    bus_req_op,
  output logic [ADDR_W-1:0]       bus_req_addr,
  input  logic                    bus_rsp_vld,
  output logic                    bus_rsp_rdy,
  input  logic [ID_W-1:0]         bus_rsp_id,
  input  logic                    bus_rsp_last,
  input  logic [BEAT_W-1:0]       bus_rsp_data,
  output logic                    lf_wr_vld,
  input  logic                    lf_wr_rdy,
  output logic [ID_W-1:0]         lf_wr_id,
  output logic [BEAT_W*BEATS-1:0] lf_wr_dat,
  output logic                    linefill_done_en,
  output logic [ID_W-1:0]         linefill_done_id,
  output logic                    evict_done_en,
  output logic [ID_W-1:0]         evict_done_id,
  output logic                    rsp_err
);

  localparam int unsigned CntW = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

  state_e state_q, state_d;

  logic              req_vld_q, req_vld_d;
  logic [ID_W-1:0]   req_id_q, req_id_d;
  logic              req_op_q, req_op_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic [MSHR_NUM-1:0] pend_vld_q, pend_vld_d;
  logic [MSHR_NUM-1:0] pend_op_q, pend_op_d;

  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0] line_q [BEATS];
  logic [BEAT_W-1:0] line_d [BEATS];

  logic            lf_done_q, lf_done_d;
  logic [ID_W-1:0] lf_id_q, lf_id_d;
  logic            ev_done_q, ev_done_d;
  logic [ID_W-1:0] ev_id_q, ev_id_d;
  logic            err_q, err_d;

  logic req_acc, rsp_acc, last_due, ev_fire, lf_fire;

  // Readiness uses the registered pend state, so a same-cycle clear never admits a reuse.
  assign downstream_req_rdy = (!req_vld_q || bus_req_rdy) && !pend_vld_q[downstream_req_id];
  assign req_acc  = downstream_req_vld && downstream_req_rdy;
  assign rsp_acc  = bus_rsp_vld && bus_rsp_rdy;
  assign last_due = (cnt_q == CntW'(BEATS - 1));

  always_comb begin
    req_vld_d  = req_vld_q;
    req_id_d   = req_id_q;
    req_op_d   = req_op_q;
    req_addr_d = req_addr_q;
    if (req_acc) begin
      req_vld_d  = 1'b1;
      req_id_d   = downstream_req_id;
      req_op_d   = downstream_req_op;
      req_addr_d = downstream_req_addr;
    end else if (bus_req_rdy) begin
      req_vld_d  = 1'b0;
    end
  end

  // Next-state and datapath updates of the response FSM.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    ev_fire  = 1'b0;
    lf_fire  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rsp_acc) begin
          if (!pend_vld_q[bus_rsp_id]) begin
            err_d = 1'b1;
          end else if (pend_op_q[bus_rsp_id]) begin
            if (bus_rsp_last) ev_fire = 1'b1;
            else              err_d   = 1'b1;
          end else if (bus_rsp_last != last_due) begin
            err_d = 1'b1;
          end else begin
            line_d[0] = bus_rsp_data;
            cur_id_d  = bus_rsp_id;
            cnt_d     = CntW'(1);
            state_d   = bus_rsp_last ? StWrite : StCollect;
          end
        end
      end
      StCollect: begin
        if (rsp_acc) begin
          if (bus_rsp_id != cur_id_q || bus_rsp_last != last_due) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < BEATS; i++) begin
              if (cnt_q == CntW'(i)) line_d[i] = bus_rsp_data;
            end
            cnt_d = cnt_q + CntW'(1);
            if (bus_rsp_last) state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (lf_wr_rdy) begin
          lf_fire = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (err_d) begin
      cnt_d   = '0;
      state_d = StIdle;
    end
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_op_d  = pend_op_q;
    if (ev_fire) pend_vld_d[bus_rsp_id] = 1'b0;
    if (lf_fire) pend_vld_d[cur_id_q]   = 1'b0;
    if (req_acc) begin
      pend_vld_d[downstream_req_id] = 1'b1;
      pend_op_d[downstream_req_id]  = downstream_req_op;
    end
    lf_done_d = lf_fire;
    lf_id_d   = lf_fire ? cur_id_q : lf_id_q;
    ev_done_d = ev_fire;
    ev_id_d   = ev_fire ? bus_rsp_id : ev_id_q;
  end

  always_comb begin
    bus_rsp_rdy = (state_q != StWrite);
    lf_wr_vld   = (state_q == StWrite);
    lf_wr_id    = cur_id_q;
    lf_wr_dat   = '0;
    for (int i = 0; i < BEATS; i++) begin
      lf_wr_dat[i*BEAT_W +: BEAT_W] = line_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_vld_q  <= 1'b0;
      req_id_q   <= '0;
      req_op_q   <= 1'b0;
      req_addr_q <= '0;
      pend_vld_q <= '0;
      pend_op_q  <= '0;
      cur_id_q   <= '0;
      cnt_q      <= '0;
      line_q     <= '{default: '0};
      lf_done_q  <= 1'b0;
      lf_id_q    <= '0;
      ev_done_q  <= 1'b0;
      ev_id_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      req_vld_q  <= req_vld_d;
      req_id_q   <= req_id_d;
      req_op_q   <= req_op_d;
      req_addr_q <= req_addr_d;
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
      cur_id_q   <= cur_id_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      lf_done_q  <= lf_done_d;
      lf_id_q    <= lf_id_d;
      ev_done_q  <= ev_done_d;
      ev_id_q    <= ev_id_d;
      err_q      <= err_d;
    end
  end

  assign bus_req_vld      = req_vld_q;
  assign bus_req_id       = req_id_q;
  assign bus_req_op       = req_op_q;
  assign bus_req_addr     = req_addr_q;
  assign linefill_done_en = lf_done_q;
  assign linefill_done_id = lf_id_q;
  assign evict_done_en    = ev_done_q;
  assign evict_done_id    = ev_id_q;
  assign rsp_err          = err_q;

endmodule

// File: tb/tb_l1d_downstream_resp.sv
// Bench for l1d_downstream_resp: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model built from queues and pend tables.
module tb_l1d_downstream_resp;

  localparam int IDW = 3;
  localparam int AW  = 40;
  localparam int BW  = 128;
  localparam int NB  = 4;
  localparam int NM  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           downstream_req_vld, downstream_req_rdy, downstream_req_op;
  logic [IDW-1:0] downstream_req_id;
  logic [AW-1:0]  downstream_req_addr;
  logic           bus_req_vld, bus_req_rdy, bus_req_op;
  logic [IDW-1:0] bus_req_id;
  logic [AW-1:0]  bus_req_addr;
  logic           bus_rsp_vld, bus_rsp_rdy, bus_rsp_last;
  logic [IDW-1:0] bus_rsp_id;
  logic [BW-1:0]  bus_rsp_data;
  logic           lf_wr_vld, lf_wr_rdy;
  logic [IDW-1:0] lf_wr_id;
  logic [BW*NB-1:0] lf_wr_dat;
  logic           linefill_done_en, evict_done_en, rsp_err;
  logic [IDW-1:0] linefill_done_id, evict_done_id;

  l1d_downstream_resp #(
    .MSHR_NUM(NM), .ID_W(IDW), .ADDR_W(AW), .BEAT_W(BW), .BEATS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .downstream_req_vld(downstream_req_vld), .downstream_req_rdy(downstream_req_rdy),
    .downstream_req_id(downstream_req_id), .downstream_req_op(downstream_req_op),
    .downstream_req_addr(downstream_req_addr),
    .bus_req_vld(bus_req_vld), .bus_req_rdy(bus_req_rdy), .bus_req_id(bus_req_id),
    .bus_req_op(bus_req_op), .bus_req_addr(bus_req_addr),
    .bus_rsp_vld(bus_rsp_vld), .bus_rsp_rdy(bus_rsp_rdy), .bus_rsp_id(bus_rsp_id),
    .bus_rsp_last(bus_rsp_last), .bus_rsp_data(bus_rsp_data),
    .lf_wr_vld(lf_wr_vld), .lf_wr_rdy(lf_wr_rdy), .lf_wr_id(lf_wr_id), .lf_wr_dat(lf_wr_dat),
    .linefill_done_en(linefill_done_en), .linefill_done_id(linefill_done_id),
    .evict_done_en(evict_done_en), .evict_done_id(evict_done_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: pend tables, outstanding bus request, and the beats collected for the open line.
  bit             m_pend [NM];
  bit             m_op   [NM];
  bit             m_rv;
  logic [IDW-1:0] m_rid;
  logic           m_rop;
  logic [AW-1:0]  m_raddr;
  logic [BW-1:0]  m_beats [$];
  logic [IDW-1:0] m_cur;
  bit             m_full;
  bit             e_lf, e_ev, e_err;
  logic [IDW-1:0] e_lfid, e_evid;

  task automatic model_reset();
    for (int i = 0; i < NM; i++) begin
      m_pend[i] = 1'b0;
      m_op[i]   = 1'b0;
    end
    m_rv = 1'b0; m_rid = '0; m_rop = 1'b0; m_raddr = '0;
    m_beats.delete();
    m_cur = '0; m_full = 1'b0;
    e_lf = 1'b0; e_ev = 1'b0; e_err = 1'b0; e_lfid = '0; e_evid = '0;
  endtask

  task automatic model_edge(input logic acc_rdy);
    int n;
    n = m_beats.size();
    e_lf = 1'b0; e_ev = 1'b0; e_err = 1'b0;
    if (m_full) begin
      if (lf_wr_rdy) begin
        m_pend[m_cur] = 1'b0;
        e_lf = 1'b1; e_lfid = m_cur;
        m_full = 1'b0;
        m_beats.delete();
      end
    end else if (bus_rsp_vld) begin
      if (n == 0 && !m_pend[bus_rsp_id]) e_err = 1'b1;
      else if (n == 0 && m_op[bus_rsp_id]) begin
        if (bus_rsp_last) begin
          m_pend[bus_rsp_id] = 1'b0;
          e_ev = 1'b1; e_evid = bus_rsp_id;
        end else e_err = 1'b1;
      end else if (n != 0 && bus_rsp_id != m_cur) e_err = 1'b1;
      else if (bus_rsp_last != (n == NB - 1)) e_err = 1'b1;
      else begin
        m_cur = bus_rsp_id;
        m_beats.push_back(bus_rsp_data);
        m_full = bus_rsp_last;
      end
      if (e_err) m_beats.delete();
    end
    if (downstream_req_vld && acc_rdy) begin
      m_rv = 1'b1; m_rid = downstream_req_id; m_rop = downstream_req_op;
      m_raddr = downstream_req_addr;
      m_pend[downstream_req_id] = 1'b1;
      m_op[downstream_req_id]   = downstream_req_op;
    end else if (bus_req_rdy) begin
      m_rv = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic           exp_rdy;
    logic [511:0]   line;
    #1;
    exp_rdy = (!m_rv || bus_req_rdy) && !m_pend[downstream_req_id];
    check_val("req_rdy", 512'(downstream_req_rdy), 512'(exp_rdy));
    check_val("rsp_rdy", 512'(bus_rsp_rdy), 512'(!m_full));
    check_val("bus_vld", 512'(bus_req_vld), 512'(m_rv));
    if (m_rv) check_val("bus_payload", 512'({bus_req_id, bus_req_op, bus_req_addr}),
                        512'({m_rid, m_rop, m_raddr}));
    check_val("lf_vld", 512'(lf_wr_vld), 512'(m_full));
    if (m_full) begin
      line = '0;
      for (int i = 0; i < NB; i++) line[i*BW +: BW] = m_beats[i];
      check_val("lf_id", 512'(lf_wr_id), 512'(m_cur));
      check_val("lf_dat", 512'(lf_wr_dat), line);
    end
    check_val("lf_done", 512'(linefill_done_en), 512'(e_lf));
    if (e_lf) check_val("lf_done_id", 512'(linefill_done_id), 512'(e_lfid));
    check_val("ev_done", 512'(evict_done_en), 512'(e_ev));
    if (e_ev) check_val("ev_done_id", 512'(evict_done_id), 512'(e_evid));
    check_val("rsp_err", 512'(rsp_err), 512'(e_err));
    if (!rst_n) model_reset();
    else        model_edge(exp_rdy);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rst_n = 1'b1;
    downstream_req_vld = 1'b0; downstream_req_id = '0; downstream_req_op = 1'b0;
    downstream_req_addr = '0;
    bus_req_rdy = 1'b1;
    bus_rsp_vld = 1'b0; bus_rsp_id = '0; bus_rsp_last = 1'b0; bus_rsp_data = '0;
    lf_wr_rdy = 1'b1;
  endtask

  task automatic send_req(input logic [IDW-1:0] id, input logic op, input logic [AW-1:0] addr);
    drive_idle();
    downstream_req_vld = 1'b1; downstream_req_id = id; downstream_req_op = op;
    downstream_req_addr = addr;
    step();
  endtask

  task automatic send_beat(input logic [IDW-1:0] id, input logic last, input logic [BW-1:0] data,
                           input logic lf_rdy);
    drive_idle();
    bus_rsp_vld = 1'b1; bus_rsp_id = id; bus_rsp_last = last; bus_rsp_data = data;
    lf_wr_rdy = lf_rdy;
    step();
  endtask

  task automatic rand_inputs();
    int n;
    n = m_beats.size();
    rst_n               = ($urandom_range(0, 199) != 0);
    downstream_req_vld  = ($urandom_range(0, 2) == 0);
    downstream_req_id   = IDW'($urandom_range(0, NM - 1));
    downstream_req_op   = 1'($urandom_range(0, 1));
    downstream_req_addr = {8'($urandom), 32'($urandom)};
    bus_req_rdy         = ($urandom_range(0, 3) != 0);
    lf_wr_rdy           = 1'($urandom_range(0, 1));
    bus_rsp_vld         = 1'($urandom_range(0, 1));
    bus_rsp_data        = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    if (n != 0 && $urandom_range(0, 9) != 0) begin
      bus_rsp_id = m_cur;
    end else begin
      bus_rsp_id = IDW'($urandom_range(0, NM - 1));
      for (int k = 0; k < 4; k++)
        if (!m_pend[bus_rsp_id]) bus_rsp_id = IDW'($urandom_range(0, NM - 1));
    end
    bus_rsp_last = (n == NB - 1) ^ ($urandom_range(0, 15) == 0);
    if (n == 0 && m_op[bus_rsp_id]) bus_rsp_last = ($urandom_range(0, 15) != 0);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();

    // Linefill id 2: four beats, then a stalled data RAM write with a blocked reuse of id 2.
    send_req(3'd2, 1'b0, 40'h1000);
    check_val("lf2_bus_req", 512'({bus_req_vld, bus_req_id, bus_req_op, bus_req_addr}),
              512'({1'b1, 3'd2, 1'b0, 40'h1000}));
    for (int i = 0; i < NB; i++) send_beat(3'd2, (i == NB - 1), BW'(10 + i), 1'b0);
    check_val("lf2_dat", 512'(lf_wr_dat), {128'hD, 128'hC, 128'hB, 128'hA});
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      lf_wr_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_id = 3'd7;
      downstream_req_vld = 1'b1; downstream_req_id = 3'd2; downstream_req_addr = 40'h2000;
      step();
    end
    check_val("lf2_hold", 512'({lf_wr_vld, bus_rsp_rdy}), 512'(2'b10));
    drive_idle();
    downstream_req_vld = 1'b1; downstream_req_id = 3'd2; downstream_req_addr = 40'h2000;
    step();
    check_val("lf2_done", 512'({linefill_done_en, linefill_done_id, downstream_req_rdy}),
              512'({1'b1, 3'd2, 1'b1}));
    step();
    drive_idle();
    step();

    // Evict id 5 with the bus stalling for three cycles.
    send_req(3'd5, 1'b1, 40'h5540);
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      bus_req_rdy = 1'b0; downstream_req_vld = 1'b1; downstream_req_id = 3'd6;
      step();
    end
    check_val("ev5_held", 512'({bus_req_vld, bus_req_id, bus_req_op, bus_req_addr}),
              512'({1'b1, 3'd5, 1'b1, 40'h5540}));
    drive_idle();
    step();
    send_beat(3'd5, 1'b1, BW'(0), 1'b1);
    check_val("ev5_done", 512'({evict_done_en, evict_done_id, linefill_done_en}),
              512'({1'b1, 3'd5, 1'b0}));

    // Protocol errors: unknown id, then a linefill that ends early.
    send_beat(3'd7, 1'b1, BW'(1), 1'b1);
    check_val("err_unknown", 512'({rsp_err, evict_done_en, linefill_done_en}), 512'(3'b100));
    send_req(3'd1, 1'b0, 40'h100);
    send_beat(3'd1, 1'b0, BW'(2), 1'b1);
    send_beat(3'd1, 1'b1, BW'(3), 1'b1);
    check_val("err_early_last", 512'({rsp_err, bus_rsp_rdy}), 512'(2'b11));
    drive_idle();
    downstream_req_vld = 1'b1; downstream_req_id = 3'd1;
    #1;
    check_val("err_pend1_kept", 512'(downstream_req_rdy), 512'(1'b0));
    step();

    // Reset in the middle of collecting a line.
    send_req(3'd3, 1'b0, 40'h300);
    send_beat(3'd3, 1'b0, BW'(4), 1'b1);
    send_beat(3'd3, 1'b0, BW'(5), 1'b1);
    drive_idle();
    rst_n = 1'b0;
    step();
    drive_idle();
    downstream_req_id = 3'd2;
    #1;
    check_val("rst_outs", 512'({bus_req_vld, lf_wr_vld, linefill_done_en, evict_done_en,
                                rsp_err, downstream_req_rdy, bus_rsp_rdy}), 512'(7'b0000011));
    step();

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1d_downstream_resp.md
L1D_DOWNSTREAM_RESP -- requirements
Module: l1d_downstream_resp

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  MSHR_NUM     8    MSHR entries / outstanding transaction IDs
  ID_W         3    log2(MSHR_NUM)
  ADDR_W       40   line address width
  BEAT_W       128  bus response data beat width
  BEATS        4    beats per cache line; LINE_W = BEAT_W*BEATS
REQ-002 SHALL have ports, one per line (name direction width meaning):
  clk                  in   1        single clock, rising edge
  rst_n                in   1        reset, synchronous, active-low
  downstream_req_vld   in   1        MSHR request valid
  downstream_req_rdy   out  1        request accepted
  downstream_req_id    in   ID_W     MSHR id
  downstream_req_op    in   1        0 = linefill, 1 = evict
  downstream_req_addr  in   ADDR_W   line address
  bus_req_vld          out  1        bus request valid
  bus_req_rdy          in   1        bus accepts request
  bus_req_id/op/addr   out  ID_W/1/ADDR_W   registered copy of the accepted request
  bus_rsp_vld          in   1        response beat valid
  bus_rsp_rdy          out  1        response beat accepted
  bus_rsp_id           in   ID_W     response id
  bus_rsp_last         in   1        final beat of the transaction
  bus_rsp_data         in   BEAT_W   beat data
  lf_wr_vld            out  1        full-line write to the data RAM
  lf_wr_rdy            in   1        data RAM accepts the write
  lf_wr_id             out  ID_W     owning MSHR id
  lf_wr_dat            out  LINE_W   assembled line, beat 0 in the LSBs
  linefill_done_en     out  1        one-cycle pulse
  linefill_done_id     out  ID_W     id for linefill_done_en
  evict_done_en        out  1        one-cycle pulse
  evict_done_id        out  ID_W     id for evict_done_en
  rsp_err              out  1        one-cycle pulse on a protocol error
REQ-003 SHALL use a single clock clk; reset rst_n is synchronous and active-low.

Function
REQ-004 SHALL hold a one-entry request register.
REQ-005 SHALL drive downstream_req_rdy = (!bus_req_vld || bus_req_rdy) && !pend_vld[downstream_req_id].
REQ-006 SHALL load the request register on an accepted request; bus_req_vld SHALL stay high and its payload stable until bus_req_rdy.
REQ-007 SHALL set pend_vld[id] and pend_op[id] on an accepted request, so latency is 1 cycle from acceptance to bus_req_vld.
REQ-008 SHALL implement response FSM states IDLE, COLLECT and WRITE.
REQ-009 SHALL drive bus_rsp_rdy = 1 in IDLE and COLLECT, and 0 in WRITE.
REQ-010 IDLE, accepted beat with pend_vld[id]=1, op=evict, last=1: SHALL clear pend_vld[id] and pulse evict_done_en/id in the next cycle; state stays IDLE.
REQ-011 IDLE, accepted beat with op=linefill: SHALL store the beat in slot 0, latch cur_id, set beat_cnt=1, and go to COLLECT; if last=1, the beat is an error per REQ-013.
REQ-012 COLLECT, beat with id == cur_id: SHALL store it in slot beat_cnt and increment beat_cnt (width log2(BEATS)+1, no wrap); if last=1 and beat_cnt == BEATS-1, go to WRITE.
REQ-013 SHALL treat these as errors: id with pend_vld=0; evict beat with last=0; last asserted early or missing on beat BEATS-1; id != cur_id in COLLECT.
REQ-014 On error, SHALL drop the beat, pulse rsp_err in the next cycle, leave pend state unchanged, and return to IDLE; a partial line is discarded and beat_cnt cleared.
REQ-015 WRITE: SHALL hold lf_wr_vld=1 with stable lf_wr_id/lf_wr_dat until lf_wr_rdy.
REQ-016 On the WRITE handshake, SHALL clear pend_vld[cur_id], pulse linefill_done_en/id in the next cycle, and return to IDLE.
REQ-017 SHALL register done/err pulses: exactly one cycle high, ids valid only while en=1.
REQ-018 Same-cycle clear of pend_vld[X] and a request for X: the request SHALL NOT be accepted that cycle (rdy sees the pre-clear state) and SHALL be accepted the next cycle.
REQ-019 SHALL allow a request accept and a response completion for different ids in the same cycle, both taking effect.
REQ-020 SHALL keep linefill_done_en and evict_done_en mutually exclusive in any cycle (guaranteed by REQ-009).

Reset
REQ-021 SHALL, while rst_n=0 at a clock edge, clear bus_req_vld, lf_wr_vld, all done/err pulses, pend_vld[*], beat_cnt and cur_id, and set the FSM to IDLE.
REQ-022 SHALL, after reset, set downstream_req_rdy=1 and bus_rsp_rdy=1; reset mid-transaction discards all in-flight state with no done pulse.

Verification
REQ-023 Linefill id 2, addr 0x1000: bus_req_vld one cycle after acceptance; 4 beats 0xA..0xD, last on beat 3 -> lf_wr_dat = {D,C,B,A}; linefill_done_en=1, id=2 one cycle after lf_wr handshake.
REQ-024 Evict id 5, bus_req_rdy=0 for 3 cycles: payload held stable; downstream_req_rdy=0 throughout; single last beat id 5 -> evict_done_en=1, id=5 next cycle.
REQ-025 Second request id 2 while id 2 is pending -> downstream_req_rdy=0 until linefill_done; accepted the cycle after pend clears.
REQ-026 Beat with unknown id 7 -> rsp_err pulse; no done pulse; pend unchanged. Linefill id 1 with last on beat 1 -> rsp_err; state IDLE; pend_vld[1] still 1.
REQ-027 lf_wr_rdy=0 for 5 cycles in WRITE -> bus_rsp_rdy=0 and lf_wr held; rst_n=0 mid-COLLECT -> all outputs 0, pend cleared, rdys 1 next cycle.
